// File: rtl/reg_pkg.sv
// Shared sizing constants and the response-queue state type for the register read port.
package reg_pkg;

    localparam int WIDTH    = 6;
    localparam int NUM_REGS = 6;
    localparam int ADDR_W   = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } q_state_t;

endpackage

// File: rtl/reg_read_port_if.sv
// Read request / response handshake between a requester (master) and the read port (slave).
interface reg_read_port_if #(
    parameter int WIDTH  = reg_pkg::WIDTH,
    parameter int ADDR_W = reg_pkg::ADDR_W
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/rsp_fifo2.sv
// Two-entry response queue; state | meaning: EMPTY | no entry, ONE | head only, FULL | head and tail.
// Valid/ready are registered alongside the state so they never depend on the consumer combinationally.
module rsp_fifo2
    import reg_pkg::*;
#(
    parameter int DW = reg_pkg::WIDTH + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic          o_valid,
    output logic          o_ready,
    output logic [DW-1:0] o_head
);
    q_state_t      r_state;
    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic          r_valid;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push & r_ready;
    assign w_pop  = i_pop & r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state <= ONE;
                        r_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && !w_pop) begin
                        r_state <= FULL;
                        r_ready <= 1'b0;
                    end else if (!w_push && w_pop) begin
                        r_state <= EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_state <= ONE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_ready = r_ready;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/reg_read_port.sv
// Register bank read port: decodes the read address, bypasses a same-cycle snooped write,
// queues responses in a 2-entry FIFO and keeps a sticky invalid-address error flag.
module reg_read_port #(
    parameter int WIDTH    = reg_pkg::WIDTH,
    parameter int NUM_REGS = reg_pkg::NUM_REGS,
    parameter int ADDR_W   = reg_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REGS*WIDTH-1:0] reg_data,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    reg_read_port_if.slave            bus,
    output logic                      err
);
    import reg_pkg::*;

    logic             w_accept;
    logic             w_pop;
    logic             w_addr_bad;
    logic             w_bypass;
    logic [WIDTH-1:0] w_slice;
    logic [WIDTH:0]   w_entry;
    logic [WIDTH:0]   w_head;
    logic             w_valid;
    logic             w_ready;
    logic             r_err;

    assign w_accept   = bus.req_valid & w_ready;
    assign w_pop      = w_valid & bus.rsp_ready;
    assign w_addr_bad = (32'(bus.req_addr) >= 32'(NUM_REGS));
    assign w_bypass   = wr_en & (wr_addr == bus.req_addr);

    always_comb begin
        w_slice = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.req_addr == ADDR_W'(i)) begin
                w_slice = reg_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Error entries carry zero data so a bad read never leaks stale register contents.
    assign w_entry = w_addr_bad ? {1'b1, {WIDTH{1'b0}}}
                   : {1'b0, (w_bypass ? wr_data : w_slice)};

    rsp_fifo2 #(
        .DW (WIDTH + 1)
    ) u_rsp_fifo2 (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_accept),
        .i_push_data (w_entry),
        .i_pop       (w_pop),
        .o_valid     (w_valid),
        .o_ready     (w_ready),
        .o_head      (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && w_addr_bad) begin
            r_err <= 1'b1;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = w_valid;
    assign bus.rsp_data  = w_head[WIDTH-1:0];
    assign bus.rsp_err   = w_head[WIDTH];
    assign err           = r_err;

endmodule

// File: tb/tb_reg_read_port.sv
// Randomized and directed bench for reg_read_port against a queue-based reference model.
module tb_reg_read_port;
    import reg_pkg::*;

    logic                      clk;
    logic                      rst;
    logic [NUM_REGS*WIDTH-1:0] reg_data;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [WIDTH-1:0]          wr_data;
    logic                      err;
    logic [WIDTH-1:0]          regs [NUM_REGS];

    logic [WIDTH:0] mq [$];
    logic           m_err;
    int             n_checks = 0;
    int             n_errors = 0;

    reg_read_port_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    reg_read_port #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reg_data (reg_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .bus      (bus),
        .err      (err)
    );

    always_comb begin
        reg_data = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_data[i*WIDTH +: WIDTH] = regs[i];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model_entry();
        int a;
        a = int'(bus.req_addr);
        if (a >= NUM_REGS) return {1'b1, {WIDTH{1'b0}}};
        if (wr_en && wr_addr == bus.req_addr) return {1'b0, wr_data};
        return {1'b0, regs[a]};
    endfunction

    task automatic check_outputs();
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(mq.size() != 0));
        check_eq("req_ready", 32'(bus.req_ready), 32'(mq.size() < 2));
        check_eq("err", 32'(err), 32'(m_err));
        if (mq.size() != 0) begin
            check_eq("rsp_data", 32'(bus.rsp_data), 32'(mq[0][WIDTH-1:0]));
            check_eq("rsp_err", 32'(bus.rsp_err), 32'(mq[0][WIDTH]));
        end
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic rr,
                         input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.rsp_ready = rr;
        wr_en         = we;
        wr_addr       = wa;
        wr_data       = wd;
    endtask

    task automatic cycle();
        logic           acc;
        logic           pp;
        logic [WIDTH:0] ent;
        acc = bus.req_valid && (mq.size() < 2);
        pp  = bus.rsp_ready && (mq.size() > 0);
        ent = model_entry();
        @(posedge clk);
        #1;
        if (pp) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(ent);
            if (ent[WIDTH]) m_err = 1'b1;
        end
        if (wr_en && int'(wr_addr) < NUM_REGS) regs[int'(wr_addr)] = wr_data;
        check_outputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check_eq({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
        check_eq({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        mq.delete();
        m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;
        check_eq("rst_release_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic random_phase(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  ADDR_W'($urandom_range(0, 7)), WIDTH'($urandom));
            if ($urandom_range(0, 1) == 1) regs[$urandom_range(0, NUM_REGS-1)] = WIDTH'($urandom);
            cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 6'h00);
        for (int i = 0; i < NUM_REGS; i++) regs[i] = WIDTH'($urandom);
        apply_reset();

        // single read of a held value
        regs[2] = 6'h2A;
        drive(1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 6'h00);
        cycle();
        check_eq("s038_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("s038_data", 32'(bus.rsp_data), 32'h2A);
        check_eq("s038_rsp_err", 32'(bus.rsp_err), 32'd0);

        // write-through bypass
        regs[4] = 6'h00;
        drive(1'b1, 3'd4, 1'b1, 1'b1, 3'd4, 6'h15);
        cycle();
        check_eq("s039_data", 32'(bus.rsp_data), 32'h15);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 6'h00);
        cycle();

        // back-pressure fills the queue, then drains in order
        regs[0] = 6'h0B;
        regs[1] = 6'h33;
        drive(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 6'h00);
        cycle();
        drive(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 6'h00);
        cycle();
        drive(1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 6'h00);
        check_eq("s040_ready_full", 32'(bus.req_ready), 32'd0);
        cycle();
        drive(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 6'h00);
        check_eq("s040_head0", 32'(bus.rsp_data), 32'h0B);
        cycle();
        check_eq("s040_head1", 32'(bus.rsp_data), 32'h33);
        cycle();
        check_eq("s040_empty", 32'(bus.rsp_valid), 32'd0);

        // simultaneous accept and pop in ONE
        drive(1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 6'h00);
        cycle();
        regs[5] = 6'h3C;
        drive(1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 6'h00);
        cycle();
        check_eq("s041_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("s041_head", 32'(bus.rsp_data), 32'h3C);
        check_eq("s041_ready", 32'(bus.req_ready), 32'd1);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 6'h00);
        cycle();

        random_phase(300);
        apply_reset();

        // invalid address and sticky err
        drive(1'b1, 3'd7, 1'b1, 1'b0, 3'd0, 6'h00);
        cycle();
        check_eq("s042_rsp_err", 32'(bus.rsp_err), 32'd1);
        check_eq("s042_data", 32'(bus.rsp_data), 32'd0);
        check_eq("s042_err", 32'(err), 32'd1);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, ADDR_W'($urandom_range(0, NUM_REGS-1)), 1'b1, 1'b0, 3'd0, 6'h00);
            cycle();
        end
        check_eq("s042_sticky", 32'(err), 32'd1);

        // asynchronous reset while FULL
        drive(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 6'h00);
        cycle();
        cycle();
        check_eq("s043_full", 32'(bus.req_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("s043");
        mq.delete();
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("s043_ready", 32'(bus.req_ready), 32'd1);
        drive(1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 6'h00);
        cycle();

        random_phase(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
